// File: rtl/div_8x4_if.sv
// rtl/div_8x4_if.sv - operand/result bundle for the 8x4 sequential divider
interface div_8x4_if;
   logic       start;
   logic [7:0] A;
   logic [3:0] B;
   logic [7:0] Q;
   logic [3:0] R;
   logic       Finish;
   logic       DZ;

   modport master (output start, A, B, input Q, R, Finish, DZ);
   modport slave  (input start, A, B, output Q, R, Finish, DZ);
endinterface

// File: rtl/div_8x4.sv
// rtl/div_8x4.sv - restoring shift/subtract 8-bit by 4-bit unsigned divider
// One quotient bit per clock; a zero divisor bypasses RUN and reports DZ.
module div_8x4 (
   input  logic       clk,
   input  logic       reset,
   div_8x4_if.slave   bus
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t     r_state;
   logic [7:0] r_w;
   logic [3:0] r_d;
   logic [3:0] r_p;
   logic [2:0] r_count;
   logic [7:0] r_q;
   logic [3:0] r_r;
   logic       r_finish;
   logic       r_dz;

   logic [4:0] w_t;
   logic [4:0] w_diff;
   logic       w_qbit;

   // Partial remainder shifted left with the next dividend bit brought in.
   assign w_t    = {r_p, r_w[7]};
   assign w_qbit = (w_t >= {1'b0, r_d});
   assign w_diff = w_t - {1'b0, r_d};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_w      <= 8'd0;
         r_d      <= 4'd0;
         r_p      <= 4'd0;
         r_count  <= 3'd0;
         r_q      <= 8'd0;
         r_r      <= 4'd0;
         r_finish <= 1'b0;
         r_dz     <= 1'b0;
      end else begin
         r_finish <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_w     <= bus.A;
                  r_d     <= bus.B;
                  r_p     <= 4'd0;
                  r_count <= 3'd0;
                  r_state <= (bus.B != 4'd0) ? S_RUN : S_DONE;
               end
            end
            S_RUN: begin
               r_p     <= w_qbit ? w_diff[3:0] : w_t[3:0];
               r_w     <= {r_w[6:0], w_qbit};
               r_count <= r_count + 3'd1;
               if (r_count == 3'd7) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               if (r_d == 4'd0) begin
                  r_q  <= 8'hFF;
                  r_r  <= 4'h0;
                  r_dz <= 1'b1;
               end else begin
                  r_q  <= r_w;
                  r_r  <= r_p;
                  r_dz <= 1'b0;
               end
               r_finish <= 1'b1;
               r_state  <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.Q      = r_q;
   assign bus.R      = r_r;
   assign bus.Finish = r_finish;
   assign bus.DZ     = r_dz;
endmodule

// File: tb/tb_div_8x4.sv
// tb/tb_div_8x4.sv - vector-table and sequence bench for div_8x4
module tb_div_8x4;
   logic clk;
   logic reset;
   int   checks;
   int   failures;

   div_8x4_if bus ();

   div_8x4 dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [3:0] b;
      logic [7:0] q;
      logic [3:0] r;
      logic       dz;
      int         lat;
   } vec_t;

   vec_t vec [7];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Launch one operation and count edges from the accepting edge to Finish.
   task automatic run_op(input logic [7:0] a, input logic [3:0] b, output int lat);
      @(negedge clk);
      bus.A = a;
      bus.B = b;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat = 0;
      while (!bus.Finish && lat < 30) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   initial begin
      int lat;
      int fin_cnt;
      int fin_at;
      int last_fin;
      logic [7:0] q_hold;
      logic [3:0] r_hold;

      checks = 0;
      failures = 0;
      vec[0] = '{a: 8'd200, b: 4'd11, q: 8'd18,  r: 4'd2, dz: 1'b0, lat: 9};
      vec[1] = '{a: 8'd255, b: 4'd1,  q: 8'd255, r: 4'd0, dz: 1'b0, lat: 9};
      vec[2] = '{a: 8'd7,   b: 4'd15, q: 8'd0,   r: 4'd7, dz: 1'b0, lat: 9};
      vec[3] = '{a: 8'd0,   b: 4'd9,  q: 8'd0,   r: 4'd0, dz: 1'b0, lat: 9};
      vec[4] = '{a: 8'd255, b: 4'd15, q: 8'd17,  r: 4'd0, dz: 1'b0, lat: 9};
      vec[5] = '{a: 8'd100, b: 4'd0,  q: 8'hFF,  r: 4'd0, dz: 1'b1, lat: 1};
      vec[6] = '{a: 8'd100, b: 4'd10, q: 8'd10,  r: 4'd0, dz: 1'b0, lat: 9};

      reset = 1'b1;
      bus.start = 1'b0;
      bus.A = 8'd0;
      bus.B = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_q", int'(bus.Q), 0);
      chk("reset_r", int'(bus.R), 0);
      chk("reset_finish", int'(bus.Finish), 0);
      chk("reset_dz", int'(bus.DZ), 0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 7; i++) begin
         run_op(vec[i].a, vec[i].b, lat);
         chk($sformatf("v%0d_latency", i), lat, vec[i].lat);
         chk($sformatf("v%0d_q", i), int'(bus.Q), int'(vec[i].q));
         chk($sformatf("v%0d_r", i), int'(bus.R), int'(vec[i].r));
         chk($sformatf("v%0d_dz", i), int'(bus.DZ), int'(vec[i].dz));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_finish_clear", i), int'(bus.Finish), 0);
         chk($sformatf("v%0d_q_hold", i), int'(bus.Q), int'(vec[i].q));
         chk($sformatf("v%0d_r_hold", i), int'(bus.R), int'(vec[i].r));
      end

      // Busy: restart attempts during RUN and on the DONE edge are ignored.
      @(negedge clk);
      bus.A = 8'd14;
      bus.B = 4'd3;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      fin_cnt = 0;
      fin_at = -1;
      for (int k = 1; k <= 15; k++) begin
         if (k == 3 || k == 9) begin
            bus.start = 1'b1;
            bus.A = 8'd250;
            bus.B = 4'd5;
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk);
         #1;
         if (bus.Finish) begin
            fin_cnt++;
            if (fin_at < 0) fin_at = k;
         end
      end
      chk("busy_finish_count", fin_cnt, 1);
      chk("busy_finish_at", fin_at, 9);
      chk("busy_q", int'(bus.Q), 4);
      chk("busy_r", int'(bus.R), 2);

      // Asynchronous reset mid-operation abandons the division.
      @(negedge clk);
      bus.A = 8'd99;
      bus.B = 4'd7;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      chk("midreset_q", int'(bus.Q), 0);
      chk("midreset_r", int'(bus.R), 0);
      chk("midreset_finish", int'(bus.Finish), 0);
      chk("midreset_dz", int'(bus.DZ), 0);
      @(negedge clk);
      reset = 1'b0;
      fin_cnt = 0;
      for (int k = 0; k < 15; k++) begin
         @(posedge clk);
         #1;
         if (bus.Finish) fin_cnt++;
      end
      chk("midreset_no_finish", fin_cnt, 0);
      run_op(8'd99, 4'd7, lat);
      chk("after_reset_latency", lat, 9);
      chk("after_reset_q", int'(bus.Q), 14);
      chk("after_reset_r", int'(bus.R), 1);

      // start held high: one result every 10 clocks.
      @(negedge clk);
      bus.A = 8'd50;
      bus.B = 4'd6;
      bus.start = 1'b1;
      fin_cnt = 0;
      last_fin = -1;
      for (int k = 0; k < 35; k++) begin
         @(posedge clk);
         #1;
         if (bus.Finish) begin
            q_hold = bus.Q;
            r_hold = bus.R;
            chk($sformatf("held_q_%0d", fin_cnt), int'(q_hold), 8);
            chk($sformatf("held_r_%0d", fin_cnt), int'(r_hold), 2);
            if (last_fin < 0) chk("held_first_at", k, 9);
            else chk($sformatf("held_period_%0d", fin_cnt), k - last_fin, 10);
            last_fin = k;
            fin_cnt++;
         end
      end
      bus.start = 1'b0;
      chk("held_finish_count", fin_cnt, 3);
      repeat (15) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
